// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with internal baud divider, optional parity and 1/2 stop bits
module uart_tx_fifo #(
  parameter int WIDTH_DATA = 8,
  parameter int NB_STOP    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_we,
  input  logic [WIDTH_DATA-1:0]         i_data,
  input  logic [DIV_WIDTH-1:0]          i_div,
  input  logic                          i_parity_en,
  input  logic                          i_parity_odd,
  output logic                          o_buf,
  output logic                          o_full,
  output logic                          o_mty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [WIDTH_DATA-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH_DATA-1:0] sh, head;
  logic [DIV_WIDTH-1:0] cnt, div_q;
  logic [3:0] bit_cnt;
  logic pen_q, pbit_q, empty, push, pop, bit_end, last_data, last_stop, buf_n;
  assign head      = mem[rd_ptr];
  assign empty     = o_level == '0;
  assign o_full    = o_level == LW'(FIFO_DEPTH);
  assign o_mty     = empty && state == IDLE;
  assign push      = i_we && !o_full;
  assign bit_end   = cnt == div_q;
  assign last_data = bit_cnt == 4'(WIDTH_DATA - 1);
  assign last_stop = bit_cnt == 4'(NB_STOP - 1);
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = empty ? IDLE : START;
      START:   state_n = bit_end ? DATA : START;
      DATA:    state_n = bit_end && last_data ? (pen_q ? PARITY : STOP) : DATA;
      PARITY:  state_n = bit_end ? STOP : PARITY;
      STOP:    state_n = bit_end && last_stop ? (empty ? IDLE : START) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // line value for the next bit is chosen one edge ahead so o_buf is a plain register
  always_comb begin
    pop   = !empty && (state == IDLE || (state == STOP && bit_end && last_stop));
    buf_n = o_buf;
    case (state)
      IDLE:    buf_n = !pop;
      START:   buf_n = bit_end ? sh[0] : o_buf;
      DATA:    buf_n = bit_end ? (last_data ? (pen_q ? pbit_q : 1'b1) : sh[1]) : o_buf;
      PARITY:  buf_n = bit_end ? 1'b1 : o_buf;
      STOP:    buf_n = bit_end && last_stop ? !pop : o_buf;
      default: buf_n = 1'b1;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
      o_ovf   <= 1'b0;
      o_buf   <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      div_q   <= '0;
      pen_q   <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      o_level <= o_level + LW'(push) - LW'(pop);
      if (i_we && o_full) o_ovf <= 1'b1;
      o_buf <= buf_n;
      if (pop) begin
        sh      <= head;
        div_q   <= i_div;
        pen_q   <= i_parity_en;
        pbit_q  <= ^head ^ i_parity_odd;
        cnt     <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + DIV_WIDTH'(1);
        if (bit_end) bit_cnt <= state_n != state ? 4'd0 : bit_cnt + 4'd1;
        if (bit_end && state == DATA) sh <= sh >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, corner sequences and a queue-based line model for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int W = 8, NS = 2, D = 4, DW = 16;
  logic i_clk = 0, i_rst = 1, i_we = 0, i_parity_en = 0, i_parity_odd = 0;
  logic [W-1:0] i_data = '0;
  logic [DW-1:0] i_div = '0;
  logic o_buf, o_full, o_mty, o_ovf;
  logic [2:0] o_level;
  uart_tx_fifo #(.WIDTH_DATA(W), .NB_STOP(NS), .FIFO_DEPTH(D), .DIV_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_we(i_we), .i_data(i_data), .i_div(i_div),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .o_buf(o_buf),
    .o_full(o_full), .o_mty(o_mty), .o_level(o_level), .o_ovf(o_ovf)
  );
  always #5 i_clk = ~i_clk;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;
  logic [W-1:0] q[$];
  logic wave[$];
  logic m_buf = 1, m_busy = 0, m_ovf = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // expands one frame into its per-clock line samples
  task automatic build(logic [W-1:0] d, int dv, logic pen, logic podd);
    logic b[$];
    b.push_back(1'b0);
    for (int i = 0; i < W; i++) b.push_back(d[i]);
    if (pen) b.push_back((^d) ^ podd);
    for (int i = 0; i < NS; i++) b.push_back(1'b1);
    foreach (b[k]) repeat (dv + 1) wave.push_back(b[k]);
  endtask
  task automatic model_step();
    bit full_pre;
    if (i_rst) begin
      q.delete(); wave.delete();
      m_buf = 1; m_busy = 0; m_ovf = 0;
    end else begin
      full_pre = q.size() == D;
      if (wave.size() == 0 && q.size() > 0) build(q.pop_front(), int'(i_div), i_parity_en, i_parity_odd);
      if (i_we) begin
        if (full_pre) m_ovf = 1;
        else q.push_back(i_data);
      end
      if (wave.size() > 0) begin m_buf = wave.pop_front(); m_busy = 1; end
      else begin m_buf = 1; m_busy = 0; end
    end
  endtask
  always @(posedge i_clk) model_step();
  always @(negedge i_clk) if (chk_en) begin
    chk("model_buf", 32'(o_buf), 32'(m_buf));
    chk("model_level", 32'(o_level), q.size());
    chk("model_full", 32'(o_full), 32'(q.size() == D));
    chk("model_mty", 32'(o_mty), 32'(q.size() == 0 && !m_busy));
    chk("model_ovf", 32'(o_ovf), 32'(m_ovf));
  end
  task automatic push(logic [W-1:0] d);
    i_we = 1; i_data = d;
    @(negedge i_clk);
    i_we = 0;
  endtask
  task automatic wait_idle(string name);
    int n = 0;
    while (!o_mty && n < 2000) begin @(negedge i_clk); n++; end
    chk(name, 32'(o_mty), 1);
  endtask
  typedef struct {
    logic [7:0] data; logic [15:0] div; logic pen; logic podd;
    logic [11:0] bits; int len;
  } vec_t;
  vec_t tv[6];
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 12'({2'b11, 8'hA5, 1'b0}), 44};
    tv[1] = '{8'h03, 16'd1, 1'b1, 1'b1, 12'({2'b11, 1'b1, 8'h03, 1'b0}), 24};
    tv[2] = '{8'h03, 16'd1, 1'b1, 1'b0, 12'({2'b11, 1'b0, 8'h03, 1'b0}), 24};
    tv[3] = '{8'h55, 16'd0, 1'b0, 1'b0, 12'({2'b11, 8'h55, 1'b0}), 11};
    tv[4] = '{8'h80, 16'd2, 1'b1, 1'b1, 12'({2'b11, 1'b0, 8'h80, 1'b0}), 36};
    tv[5] = '{8'hFF, 16'd0, 1'b1, 1'b0, 12'({2'b11, 1'b0, 8'hFF, 1'b0}), 12};
    @(negedge i_clk);
    chk_en = 1;
    chk("rst_buf", 32'(o_buf), 1);
    chk("rst_level", 32'(o_level), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_mty", 32'(o_mty), 1);
    chk("rst_ovf", 32'(o_ovf), 0);
    i_rst = 0;
    @(negedge i_clk);
    foreach (tv[v]) begin
      int p, c;
      logic [11:0] cap;
      wait_idle("vec_idle");
      i_div = tv[v].div; i_parity_en = tv[v].pen; i_parity_odd = tv[v].podd;
      push(tv[v].data);
      p = int'(tv[v].div) + 1;
      cap = '0;
      for (c = 0; c < 500; c++) begin
        @(negedge i_clk);
        if (c == 0) begin i_div = 16'd5; i_parity_en = ~i_parity_en; i_parity_odd = ~i_parity_odd; end
        if (o_mty) break;
        if (c % p == 0 && c / p < 12) cap[c / p] = o_buf;
      end
      chk($sformatf("vec%0d_len", v), c, tv[v].len);
      chk($sformatf("vec%0d_bits", v), 32'(cap), 32'(tv[v].bits));
    end
    begin : back_to_back
      wait_idle("b2b_idle");
      i_div = 16'd1; i_parity_en = 0;
      i_we = 1; i_data = 8'h00;
      @(negedge i_clk);
      i_data = 8'hFF;
      @(negedge i_clk);
      i_we = 0;
      for (int c = 0; c <= 44; c++) begin
        if (c == 0) chk("b2b_start0", 32'(o_buf), 0);
        if (c == 21) chk("b2b_last_stop", 32'(o_buf), 1);
        if (c == 22) chk("b2b_start1", 32'(o_buf), 0);
        if (c == 22) chk("b2b_busy", 32'(o_mty), 0);
        if (c == 24) chk("b2b_data1", 32'(o_buf), 1);
        if (c == 44) chk("b2b_done", 32'(o_mty), 1);
        @(negedge i_clk);
      end
    end
    begin : overflow
      int n_dec, cyc;
      logic [2:0] prev;
      wait_idle("ovf_idle");
      i_div = 16'd7;
      push(8'h11);
      @(negedge i_clk);
      i_we = 1;
      for (int k = 0; k < 5; k++) begin
        i_data = 8'h20 + 8'(k);
        @(negedge i_clk);
      end
      i_we = 0;
      chk("ovf_full", 32'(o_full), 1);
      chk("ovf_level", 32'(o_level), 4);
      chk("ovf_flag", 32'(o_ovf), 1);
      n_dec = 0; cyc = 0; prev = o_level;
      while (!o_mty && cyc < 1000) begin
        @(negedge i_clk);
        cyc++;
        if (o_level < prev) n_dec++;
        prev = o_level;
      end
      chk("ovf_frames", n_dec, 4);
      chk("ovf_drain_cycles", cyc, 435);
      chk("ovf_sticky", 32'(o_ovf), 1);
    end
    begin : reset_mid
      logic saw_low;
      wait_idle("rst_idle");
      i_div = 16'd3; i_parity_en = 0;
      push(8'hC3);
      i_we = 1; i_data = 8'h3C;
      @(negedge i_clk);
      i_data = 8'h5A;
      @(negedge i_clk);
      i_we = 0;
      repeat (12) @(negedge i_clk);
      chk("mid_level", 32'(o_level), 2);
      i_rst = 1;
      @(negedge i_clk);
      i_rst = 0;
      chk("mid_rst_buf", 32'(o_buf), 1);
      chk("mid_rst_level", 32'(o_level), 0);
      chk("mid_rst_mty", 32'(o_mty), 1);
      chk("mid_rst_ovf", 32'(o_ovf), 0);
      saw_low = 0;
      repeat (60) begin @(negedge i_clk); saw_low |= !o_buf; end
      chk("mid_rst_quiet", 32'(saw_low), 0);
      chk("mid_rst_still_mty", 32'(o_mty), 1);
    end
    for (int n = 0; n < 4000; n++) begin
      i_we = $urandom_range(0, 2) == 0;
      i_data = 8'($urandom);
      i_div = 16'($urandom_range(0, 3));
      i_parity_en = 1'($urandom);
      i_parity_odd = 1'($urandom);
      i_rst = $urandom_range(0, 699) == 0;
      @(negedge i_clk);
    end
    i_we = 0; i_rst = 0;
    wait_idle("final_drain");
    @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
